// File: rtl/mem_access.sv
// Memory-access pipeline stage: branch resolution, data-memory request/ready handshake,
// upstream stall generation and the MEM/WB register. Optional wait-state timeout: MEM_TIMEOUT_EN.
module mem_access #(
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [1:0]        wb_ctl,
  input  logic              branch,
  input  logic              memread,
  input  logic              memwrite,
  input  logic              zero,
  input  logic [DATA_W-1:0] EX_MEM_NPC,
  input  logic [DATA_W-1:0] alu_result,
  input  logic [DATA_W-1:0] rdata2,
  input  logic [4:0]        rd,
  output logic              mem_req,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ready,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              pcsrc,
  output logic [DATA_W-1:0] branch_target,
  output logic              stall,
  output logic [1:0]        mem_wb_ctl,
  output logic [DATA_W-1:0] mem_wb_rdata,
  output logic [DATA_W-1:0] mem_wb_alu,
  output logic [4:0]        mem_wb_rd,
  output logic              mem_err
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_t;

  state_t state_r;
  state_t state_nxt_s;

  logic acc_s;
  logic timeout_s;
  logic mem_req_s;
  logic stall_s;
  logic bubble_s;

  logic [1:0]        wb_ctl_r;
  logic [DATA_W-1:0] wb_rdata_r;
  logic [DATA_W-1:0] wb_alu_r;
  logic [4:0]        wb_rd_r;

  assign acc_s = memread | memwrite;

  // The handshake and branch outputs are combinational but must vanish the instant reset asserts.
  assign mem_req       = rst_n & mem_req_s;
  assign stall         = rst_n & stall_s;
  assign pcsrc         = rst_n & branch & zero;
  assign branch_target = EX_MEM_NPC;
  assign mem_we        = memwrite;
  assign mem_addr      = alu_result;
  assign mem_wdata     = rdata2;

`ifdef MEM_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  logic [CNT_W-1:0] cnt_r;
  logic             err_r;

  // Final unanswered wait cycle: abandon the access instead of stalling again.
  assign timeout_s = (state_r == WAIT) && !mem_ready &&
                     (cnt_r == CNT_W'(TIMEOUT_CYCLES - 1));

  // Wait-state counter, cleared whenever the FSM is not sitting in an unanswered WAIT.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if ((state_r == WAIT) && !mem_ready && !timeout_s) begin
      cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      cnt_r <= {CNT_W{1'b0}};
    end
  end

  // Sticky timeout error flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_r <= 1'b0;
    end else if (timeout_s) begin
      err_r <= 1'b1;
    end else begin
      err_r <= err_r;
    end
  end

  assign mem_err = err_r;
`else
  assign timeout_s = 1'b0;
  assign mem_err   = 1'b0;
`endif

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (acc_s && !mem_ready) begin
          state_nxt_s = WAIT;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      WAIT: begin
        if (mem_ready || timeout_s) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = WAIT;
        end
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // FSM outputs: request, stall and bubble insertion.
  always_comb begin
    mem_req_s = 1'b0;
    stall_s   = 1'b0;
    case (state_r)
      IDLE: begin
        mem_req_s = acc_s;
        stall_s   = acc_s & ~mem_ready;
      end
      WAIT: begin
        mem_req_s = 1'b1;
        stall_s   = ~mem_ready & ~timeout_s;
      end
      default: begin
        mem_req_s = 1'b0;
        stall_s   = 1'b0;
      end
    endcase
  end

  // A stalled or timed-out cycle must not retire anything into write-back.
  assign bubble_s = stall_s | timeout_s;

  // MEM/WB pipeline register, loaded every cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_ctl_r   <= 2'b00;
      wb_rdata_r <= {DATA_W{1'b0}};
      wb_alu_r   <= {DATA_W{1'b0}};
      wb_rd_r    <= 5'd0;
    end else begin
      wb_ctl_r   <= bubble_s ? 2'b00 : wb_ctl;
      wb_rdata_r <= mem_rdata;
      wb_alu_r   <= alu_result;
      wb_rd_r    <= rd;
    end
  end

  assign mem_wb_ctl   = wb_ctl_r;
  assign mem_wb_rdata = wb_rdata_r;
  assign mem_wb_alu   = wb_alu_r;
  assign mem_wb_rd    = wb_rd_r;

endmodule

// File: doc/mem_access.md
Name: mem_access

Overview:
- Memory-access stage directly downstream of the execute stage; consumes the EX/MEM pipeline register outputs.
- Resolves branches (pcsrc/target) and drives a word-wide data-memory request/ready handshake.
- Stalls the upstream pipeline while a memory access is outstanding.
- Contains the MEM/WB pipeline register feeding write-back.

Parameters:
- DATA_W, 32, width of data, address and NPC paths
- TIMEOUT_CYCLES, 16, wait-state limit when MEM_TIMEOUT_EN is defined (min 1)

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- wb_ctl  in  2  EX/MEM write-back control {regwrite, memtoreg}
- branch  in  1  EX/MEM branch flag
- memread  in  1  EX/MEM load request
- memwrite  in  1  EX/MEM store request
- zero  in  1  EX/MEM ALU zero flag
- EX_MEM_NPC  in  DATA_W  EX/MEM branch target
- alu_result  in  DATA_W  EX/MEM ALU result / memory address
- rdata2  in  DATA_W  EX/MEM store data
- rd  in  5  EX/MEM destination register
- mem_req  out  1  data-memory request
- mem_we  out  1  1 = write, 0 = read
- mem_addr  out  DATA_W  memory address
- mem_wdata  out  DATA_W  store data
- mem_ready  in  1  memory completes current request this cycle
- mem_rdata  in  DATA_W  load data, valid when mem_ready=1
- pcsrc  out  1  take branch
- branch_target  out  DATA_W  next PC when pcsrc=1
- stall  out  1  freeze PC, IF/ID, ID/EX and EX/MEM this cycle
- mem_wb_ctl  out  2  MEM/WB write-back control
- mem_wb_rdata  out  DATA_W  MEM/WB load data
- mem_wb_alu  out  DATA_W  MEM/WB ALU result
- mem_wb_rd  out  5  MEM/WB destination register
- mem_err  out  1  sticky timeout flag

Behaviour:
- Reset, async on rst_n=0:
  - state=IDLE; all MEM/WB outputs 0; mem_err=0; timeout counter 0.
  - mem_req, stall and pcsrc deassert immediately.
- Branch resolution (combinational):
  - pcsrc = branch & zero; branch_target = EX_MEM_NPC.
  - Branches never access memory, so pcsrc is independent of stall.
- Access: acc = memread | memwrite.
  - mem_we = memwrite; write wins if both memread and memwrite are set; the load data is then discarded but wb_ctl passes through unchanged.
  - mem_addr = alu_result (full byte address, no alignment check); mem_wdata = rdata2.
- FSM states: IDLE, WAIT.
- IDLE:
  - mem_req = acc.
  - acc & mem_ready: zero-wait completion. MEM/WB captures at the next edge; stall=0.
  - acc & !mem_ready: go to WAIT; stall=1; MEM/WB loads a bubble (mem_wb_ctl=0, other fields don't-care but loaded with current values).
  - !acc: MEM/WB captures wb_ctl, alu_result, rd; mem_wb_rdata = mem_rdata (don't-care).
- WAIT:
  - mem_req=1; address and data stay stable because upstream is frozen by stall.
  - mem_ready=1: stall=0, MEM/WB captures normally including mem_rdata, go to IDLE.
  - Else stall=1, bubble inserted, remain in WAIT.
- Latency:
  - 1 cycle from stage entry to MEM/WB when mem_ready is high immediately.
  - Otherwise 1 + wait cycles.
- Back-to-back accesses: a new access may be issued in the IDLE cycle immediately following a completion.
- mem_ready while mem_req=0 is ignored.
- Reset during WAIT abandons the transaction; mem_req drops asynchronously.

Optional Feature:
- Macro: MEM_TIMEOUT_EN.
- Defined:
  - Counter increments on each WAIT cycle without mem_ready.
  - When the counter reaches TIMEOUT_CYCLES: go to IDLE, stall=0, MEM/WB gets a bubble for the instruction, mem_err set (sticky until reset), counter cleared.
  - Counter is cleared on every entry to IDLE.
  - mem_ready in the timeout cycle takes priority and completes normally.
- Not defined: no counter; WAIT holds indefinitely; mem_err tied 0.

Test Plan:
- Reset mid-WAIT:
  - Stimulus: load to 0x20, mem_ready held 0 for 3 cycles; assert rst_n=0.
  - Response: mem_req and stall drop at once; all MEM/WB outputs 0; state IDLE after release.
- Zero-wait load:
  - Stimulus: memread=1, alu_result=0x40, rd=5, wb_ctl=2'b11, mem_ready=1, mem_rdata=0xDEADBEEF.
  - Response: stall=0; next cycle mem_wb_rdata=0xDEADBEEF, mem_wb_rd=5, mem_wb_ctl=2'b11.
- Store with 2 wait states:
  - Stimulus: memwrite=1, addr 0x100, rdata2=0x12345678; mem_ready high on 3rd cycle.
  - Response: mem_we=1 and addr/data stable for 3 cycles; stall=1 for 2 cycles; two bubbles (mem_wb_ctl=0); then stored instruction's ctl appears.
- Branch:
  - Stimulus: branch=1, zero=1, EX_MEM_NPC=0x80.
  - Response: pcsrc=1, branch_target=0x80 same cycle. With zero=0: pcsrc=0.
- Dual request:
  - Stimulus: memread=1 and memwrite=1, mem_ready=1.
  - Response: mem_we=1; a single request is issued.
- Timeout (MEM_TIMEOUT_EN, TIMEOUT_CYCLES=4):
  - Stimulus: mem_ready stuck 0.
  - Response: after 4 WAIT cycles stall=0, mem_err=1, and mem_err stays 1 through later accesses until reset.
